// File: rtl/ptcalc_mul_arbiter.sv
// Shares one 17-bit unsigned x 28-bit signed multiplier among NREQ requesters.
// Define PTCALC_MUL_ARB_RR_EN for round-robin grant; otherwise lowest index wins.
module ptcalc_mul_arbiter #(
    parameter int NREQ       = 3,
    parameter int MUL_STAGES = 2,
    parameter int ID_W       = 3
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*17-1:0]   req_a,
    input  logic [NREQ*28-1:0]   req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [44:0]          res_p,
    output logic [ID_W-1:0]      res_id
);

    logic            stall;
    logic            accept;
    logic            grant_any;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    logic [16:0]     sel_a;
    logic [27:0]     sel_b;
    logic [ID_W-1:0] base;

    // Zero-extended a times sign-extended b; the low 45 bits are the exact signed product.
    function automatic logic [44:0] mul45(input logic [16:0] a, input logic [27:0] b);
        return {28'd0, a} * {{17{b[27]}}, b};
    endfunction

    assign stall = res_valid & ~res_ready;

`ifdef PTCALC_MUL_ARB_RR_EN
    logic [ID_W-1:0] ptr;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    assign base = ptr;
`else
    assign base = '0;
`endif

    // Search order k = 0.. visits requester (base + k) mod NREQ.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any && req_valid[i] &&
                    ((int'(base) + k == i) || (int'(base) + k == i + NREQ))) begin
                    grant_any = 1'b1;
                    grant[i]  = 1'b1;
                    grant_id  = ID_W'(i);
                    sel_a     = req_a[i*17 +: 17];
                    sel_b     = req_b[i*28 +: 28];
                end
            end
        end
    end

    assign req_ready = (ap_rst || stall) ? '0 : grant;
    assign accept    = |(req_valid & req_ready);

    generate
        if (MUL_STAGES == 1) begin : g_comb_mul
            logic            out_v;
            logic [44:0]     out_p;
            logic [ID_W-1:0] out_id;

            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    out_v  <= 1'b0;
                    out_p  <= '0;
                    out_id <= '0;
                end else if (!stall) begin
                    out_v  <= accept;
                    out_p  <= mul45(sel_a, sel_b);
                    out_id <= grant_id;
                end
            end

            assign res_valid = out_v;
            assign res_p     = out_p;
            assign res_id    = out_id;
        end else begin : g_pipe_mul
            logic            s1_v;
            logic [16:0]     s1_a;
            logic [27:0]     s1_b;
            logic [ID_W-1:0] s1_id;
            logic            pv  [2:MUL_STAGES];
            logic [44:0]     pp  [2:MUL_STAGES];
            logic [ID_W-1:0] pid [2:MUL_STAGES];

            // Stage 1 holds operands; the multiply sits between stage 1 and stage 2.
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    s1_v  <= 1'b0;
                    s1_a  <= '0;
                    s1_b  <= '0;
                    s1_id <= '0;
                    for (int j = 2; j <= MUL_STAGES; j++) begin
                        pv[j]  <= 1'b0;
                        pp[j]  <= '0;
                        pid[j] <= '0;
                    end
                end else if (!stall) begin
                    s1_v   <= accept;
                    s1_a   <= sel_a;
                    s1_b   <= sel_b;
                    s1_id  <= grant_id;
                    pv[2]  <= s1_v;
                    pp[2]  <= mul45(s1_a, s1_b);
                    pid[2] <= s1_id;
                    for (int j = 3; j <= MUL_STAGES; j++) begin
                        pv[j]  <= pv[j-1];
                        pp[j]  <= pp[j-1];
                        pid[j] <= pid[j-1];
                    end
                end
            end

            assign res_valid = pv[MUL_STAGES];
            assign res_p     = pp[MUL_STAGES];
            assign res_id    = pid[MUL_STAGES];
        end
    endgenerate

endmodule

// File: tb/tb_ptcalc_mul_arbiter.sv
// Randomized and directed bench for ptcalc_mul_arbiter against an in-order
// queue model of accepted requests and their exact products.
`timescale 1ns/1ps
module tb_ptcalc_mul_arbiter;
    localparam int NREQ       = 3;
    localparam int MUL_STAGES = 2;
    localparam int ID_W       = 3;
`ifdef PTCALC_MUL_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                ap_clk = 1'b0;
    logic                ap_rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*17-1:0]  req_a = '0;
    logic [NREQ*28-1:0]  req_b = '0;
    logic                res_valid;
    logic                res_ready = 1'b1;
    logic [44:0]         res_p;
    logic [ID_W-1:0]     res_id;

    ptcalc_mul_arbiter #(.NREQ(NREQ), .MUL_STAGES(MUL_STAGES), .ID_W(ID_W)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_id(res_id)
    );

    always #5 ap_clk = ~ap_clk;

    // Each accepted request waits MUL_STAGES unstalled edges before it is visible.
    typedef struct { logic [44:0] p; logic [ID_W-1:0] id; int adv; } item_t;
    item_t q[$];
    int mptr = 0;
    logic [16:0] op_a [NREQ];
    logic [27:0] op_b [NREQ];

    logic            exp_rv, exp_stall;
    logic [44:0]     exp_p;
    logic [ID_W-1:0] exp_id;
    logic [NREQ-1:0] exp_ready;
    int              exp_acc;
    int checks = 0, errors = 0, n_acc = 0, n_res = 0;

    function automatic logic [44:0] ref_mul(input logic [16:0] a, input logic [27:0] b);
        longint sb, prod;
        sb   = longint'($signed(b));
        prod = longint'(a) * sb;
        return prod[44:0];
    endfunction

    task automatic apply_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*17 +: 17] = op_a[i];
            req_b[i*28 +: 28] = op_b[i];
        end
    endtask

    task automatic new_ops(input int i);
        op_a[i] = 17'($urandom);
        op_b[i] = 28'($urandom);
    endtask

    task automatic model_eval();
        @(negedge ap_clk);
        exp_rv    = (q.size() > 0) && (q[0].adv == MUL_STAGES);
        exp_p     = exp_rv ? q[0].p : '0;
        exp_id    = exp_rv ? q[0].id : '0;
        exp_stall = exp_rv && !res_ready;
        exp_ready = '0;
        exp_acc   = -1;
        if (!exp_stall && !ap_rst) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = RR ? (mptr + k) % NREQ : k;
                if (exp_acc < 0 && req_valid[idx]) begin
                    exp_acc = idx;
                    exp_ready[idx] = 1'b1;
                end
            end
        end
        if (res_valid === 1'b1 && res_ready) n_res++;
    endtask

    task automatic model_step();
        item_t it;
        @(posedge ap_clk);
        if (ap_rst) begin
            q.delete();
            mptr = 0;
        end else if (!exp_stall) begin
            if (exp_rv && res_ready) void'(q.pop_front());
            foreach (q[i]) q[i].adv = q[i].adv + 1;
            if (exp_acc >= 0) begin
                it.p   = ref_mul(op_a[exp_acc], op_b[exp_acc]);
                it.id  = ID_W'(exp_acc);
                it.adv = 1;
                q.push_back(it);
                mptr = (exp_acc + 1) % NREQ;
                n_acc++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        model_eval();
        model_step();
        ap_rst = 1'b0;
        n_acc = 0;
        n_res = 0;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        req_valid = '1;
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        apply_ops();
        for (int c = 0; c < 3; c++) begin
            model_eval();
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready c=%0d got=%b want=0", c, req_ready); end
            if (c > 0) begin
                checks++;
                if (res_valid !== 1'b0 || res_p !== 45'd0 || res_id !== '0) begin
                    errors++; $display("FAIL reset_out c=%0d got v=%b p=%h id=%0d want 0/0/0", c, res_valid, res_p, res_id);
                end
            end
            model_step();
        end
        ap_rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        op_a[1] = 17'h1FFFF;
        op_b[1] = 28'h8000000;
        req_valid = 3'b010;
        res_ready = 1'b1;
        apply_ops();
        for (int c = 0; c < 5; c++) begin
            model_eval();
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL single_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
            checks++; if (res_valid !== exp_rv) begin errors++; $display("FAIL single_valid c=%0d got=%b want=%b", c, res_valid, exp_rv); end
            if (c == 2) begin
                checks++;
                if (res_valid !== 1'b1 || res_p !== 45'h100008000000 || res_id !== 3'd1) begin
                    errors++; $display("FAIL single_result got v=%b p=%h id=%0d want 1/100008000000/1", res_valid, res_p, res_id);
                end
            end
            model_step();
            if (exp_acc == 1) req_valid = '0;
        end
    endtask

    task automatic test_rotation();
        int seq [6];
        for (int k = 0; k < 6; k++) seq[k] = RR ? k % NREQ : 0;
        do_reset();
        for (int i = 0; i < NREQ; i++) new_ops(i);
        req_valid = '1;
        res_ready = 1'b1;
        apply_ops();
        for (int c = 0; c < 8; c++) begin
            model_eval();
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rot_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
            checks++; if (res_valid !== exp_rv) begin errors++; $display("FAIL rot_valid c=%0d got=%b want=%b", c, res_valid, exp_rv); end
            if (exp_rv) begin checks++; if ({res_id, res_p} !== {exp_id, exp_p}) begin errors++; $display("FAIL rot_data c=%0d got id=%0d p=%h want id=%0d p=%h", c, res_id, res_p, exp_id, exp_p); end end
            if (c < 6) begin
                checks++; if (req_ready !== (NREQ'(1) << seq[c])) begin errors++; $display("FAIL rot_order c=%0d got=%b want=%b", c, req_ready, NREQ'(1) << seq[c]); end
            end
            if (c >= 2) begin
                checks++; if (res_valid !== 1'b1 || res_id !== ID_W'(seq[c-2])) begin errors++; $display("FAIL rot_id c=%0d got v=%b id=%0d want 1/%0d", c, res_valid, res_id, seq[c-2]); end
            end
            model_step();
            if (exp_acc >= 0) begin new_ops(exp_acc); apply_ops(); end
        end
    endtask

    task automatic test_backpressure();
        logic [44:0]     hold_p;
        logic [ID_W-1:0] hold_id;
        hold_p = '0;
        hold_id = '0;
        do_reset();
        for (int i = 0; i < NREQ; i++) new_ops(i);
        req_valid = '1;
        apply_ops();
        for (int c = 0; c < 14; c++) begin
            res_ready = !(c >= 3 && c < 8);
            if (c >= 9) req_valid = '0;
            model_eval();
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL bp_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
            checks++; if (res_valid !== exp_rv) begin errors++; $display("FAIL bp_valid c=%0d got=%b want=%b", c, res_valid, exp_rv); end
            if (exp_rv) begin checks++; if ({res_id, res_p} !== {exp_id, exp_p}) begin errors++; $display("FAIL bp_data c=%0d got id=%0d p=%h want id=%0d p=%h", c, res_id, res_p, exp_id, exp_p); end end
            if (c == 3) begin hold_p = exp_p; hold_id = exp_id; end
            if (c >= 3 && c < 8) begin
                checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_stall_ready c=%0d got=%b want=0", c, req_ready); end
                checks++; if (res_p !== hold_p || res_id !== hold_id) begin errors++; $display("FAIL bp_hold c=%0d got p=%h id=%0d want p=%h id=%0d", c, res_p, res_id, hold_p, hold_id); end
            end
            model_step();
            if (exp_acc >= 0) begin new_ops(exp_acc); apply_ops(); end
        end
        checks++;
        if (n_res != n_acc || q.size() != 0) begin
            errors++; $display("FAIL bp_count got results=%0d want=%0d (left in model %0d)", n_res, n_acc, q.size());
        end
    endtask

    task automatic test_sign_corners();
        logic [16:0] ca [3];
        logic [27:0] cb [3];
        logic [44:0] cp [3];
        ca = '{17'd0, 17'd1, 17'h1FFFF};
        cb = '{28'hFFFFFFF, 28'h7FFFFFF, 28'hFFFFFFF};
        cp = '{45'd0, 45'd134217727, 45'h1FFFFFFE0001};
        do_reset();
        res_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            op_a[0] = ca[j];
            op_b[0] = cb[j];
            req_valid = 3'b001;
            apply_ops();
            for (int c = 0; c < 3; c++) begin
                model_eval();
                checks++; if (res_valid !== exp_rv) begin errors++; $display("FAIL sign_valid j=%0d c=%0d got=%b want=%b", j, c, res_valid, exp_rv); end
                if (c == 2) begin
                    checks++;
                    if (res_valid !== 1'b1 || res_p !== cp[j] || res_id !== '0) begin
                        errors++; $display("FAIL sign_corner j=%0d got v=%b p=%h id=%0d want 1/%h/0", j, res_valid, res_p, res_id, cp[j]);
                    end
                end
                model_step();
                if (exp_acc == 0) req_valid = '0;
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < NREQ; i++) new_ops(i);
        req_valid = '1;
        res_ready = 1'b1;
        apply_ops();
        for (int c = 0; c < 8; c++) begin
            ap_rst = (c == 2);
            model_eval();
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL mid_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
            checks++; if (res_valid !== exp_rv) begin errors++; $display("FAIL mid_valid c=%0d got=%b want=%b", c, res_valid, exp_rv); end
            if (exp_rv) begin checks++; if ({res_id, res_p} !== {exp_id, exp_p}) begin errors++; $display("FAIL mid_data c=%0d got id=%0d p=%h want id=%0d p=%h", c, res_id, res_p, exp_id, exp_p); end end
            if (c == 3 || c == 4) begin
                checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_flush c=%0d got=%b want=0", c, res_valid); end
            end
            if (c == 3) begin
                checks++; if (req_ready !== NREQ'(1)) begin errors++; $display("FAIL mid_ptr got=%b want=001", req_ready); end
            end
            model_step();
            if (exp_acc >= 0) begin new_ops(exp_acc); apply_ops(); end
        end
        ap_rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            model_eval();
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
            checks++; if (res_valid !== exp_rv) begin errors++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, res_valid, exp_rv); end
            if (exp_rv) begin checks++; if ({res_id, res_p} !== {exp_id, exp_p}) begin errors++; $display("FAIL rnd_data c=%0d got id=%0d p=%h want id=%0d p=%h", c, res_id, res_p, exp_id, exp_p); end end
            model_step();
            for (int i = 0; i < NREQ; i++) begin
                if (exp_acc == i || !req_valid[i]) begin
                    req_valid[i] = (c < 570) && ($urandom_range(99) < 55);
                    new_ops(i);
                end
            end
            res_ready = (c >= 570) || ($urandom_range(99) < 70);
            apply_ops();
        end
        checks++;
        if (n_res != n_acc || q.size() != 0) begin
            errors++; $display("FAIL rnd_count got results=%0d want=%0d (left in model %0d)", n_res, n_acc, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_sign_corners();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
